lsu_addr_stage: RTL and testbench
=================================

// Module: lsu_addr_stage
// PURPOSE
//   LSU address-generation pipeline stage directly upstream of the dTLB/dcache request port.
//   Accepts load/store micro-ops from the LSU issue queue and computes vaddr = base + offset.
//   Flags misaligned accesses.
//   Presents one registered request per cycle downstream through a 2-entry skid buffer (output reg + skid reg).
//   Full-throughput valid/ready on both sides; issue_ready_o is driven from a flop.
// PARAMETERS
//   XLEN              64  width of base/offset operands
//   VIRTUAL_ADDR_LEN  39  width of generated virtual address
//   ROB_INDEX_WIDTH   6   width of ROB tag carried with each request
// PORTS
//   clk                 in   1                 clock; all state updates on rising edge
//   rst                 in   1                 synchronous reset, active-high
//   flush_i             in   1                 pipeline flush; kills all held and incoming ops
//   issue_valid_i       in   1                 issue queue presents an op
//   issue_ready_o       out  1                 stage can accept an op this cycle
//   issue_base_i        in   XLEN              rs1 value
//   issue_offset_i      in   XLEN              sign-extended immediate
//   issue_is_load_i     in   1                 1 = load, 0 = store
//   issue_size_i        in   2                 0=B,1=H,2=W,3=D
//   issue_rob_idx_i     in   ROB_INDEX_WIDTH   ROB tag
//   req_valid_o         out  1                 request to dTLB/dcache valid
//   req_ready_i         in   1                 downstream accepts request
//   req_vaddr_o         out  VIRTUAL_ADDR_LEN  generated virtual address
//   req_is_load_o       out  1                 load/store
//   req_size_o          out  2                 access size
//   req_rob_idx_o       out  ROB_INDEX_WIDTH   ROB tag
//   req_misalign_o      out  1                 vaddr not naturally aligned for req_size_o
// BEHAVIOUR
//   - Address: vaddr = base[VA-1:0] + offset[VA-1:0], modulo 2^VIRTUAL_ADDR_LEN.
//     Carry out is discarded; upper XLEN bits are ignored.
//   - Misalign (computed on vaddr at capture):
//     size 0 -> 0; size 1 -> vaddr[0]; size 2 -> |vaddr[1:0]; size 3 -> |vaddr[2:0].
//     A misaligned op is still issued downstream with the flag set; this stage raises no exception itself.
//   - Handshakes: issue fires on issue_valid_i & issue_ready_o; req fires on req_valid_o & req_ready_i.
//     Payload is held stable while req_valid_o=1 and not accepted.
//   - Latency: an op fired into an EMPTY stage appears on req_* the next cycle.
//   - States (out_v, skid_v):
//     EMPTY (0,0): issue fire -> ONE.
//     ONE (1,0):
//       issue fire & req fire -> ONE (new op to out reg);
//       issue fire & !req fire -> FULL (new op to skid);
//       !issue fire & req fire -> EMPTY.
//     FULL (1,1): issue_ready_o=0.
//       req fire -> ONE (skid moves to out reg, order preserved).
//   - issue_ready_o = !skid_v, registered. Ops leave in issue order.
//   - flush_i=1: next cycle out_v=skid_v=0 and issue_ready_o=1.
//     An op firing in the flush cycle is dropped.
//     A request accepted downstream in the flush cycle counts as delivered.
//     flush_i has priority over all other events.
//   - Reset: req_valid_o=0, issue_ready_o=1, all req payload outputs = 0, state EMPTY.
//     rst mid-operation discards held ops identically to flush.
//   - Boundary cases:
//     * Simultaneous issue fire and req fire in FULL is impossible (ready=0).
//     * vaddr wrap at 2^VA is legal and silent.
// TESTING
//   1 Single op: base=0x1000, off=0x10, size=3, load, EMPTY
//     -> next cycle req_valid_o=1, vaddr=0x1010, misalign=0.
//   2 Wrap and misalign: base=0x7F_FFFF_FFFF, off=1, size=1
//     -> vaddr=0x0, misalign=0.
//     base=0x1001, off=0, size=2 -> misalign=1.
//   3 Backpressure: 3 back-to-back ops with req_ready_i=0
//     -> ops 1,2 held; issue_ready_o=0 after op2.
//     Release -> ops 1,2,3 delivered in order; none lost or duplicated.
//   4 Streaming: issue_valid_i=1 and req_ready_i=1 every cycle for 20 ops
//     -> 1 req/cycle, issue_ready_o stays 1.
//   5 Flush in FULL together with a new issue_valid_i
//     -> next cycle req_valid_o=0, issue_ready_o=1; no flushed op ever appears on req_*.
//   6 rst asserted for 1 cycle while in ONE state
//     -> all outputs at reset values next cycle; normal operation resumes after.

Source files
------------

// File: rtl/lsu_addr_stage.sv
// LSU address-generation stage: vaddr = base + offset, misalign flag, and a
// two-entry skid buffer (output reg + skid reg) toward the dTLB/dcache port.
module lsu_addr_stage #(
  parameter int XLEN             = 64,
  parameter int VIRTUAL_ADDR_LEN = 39,
  parameter int ROB_INDEX_WIDTH  = 6
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        flush_i,
  input  logic                        issue_valid_i,
  output logic                        issue_ready_o,
  input  logic [XLEN-1:0]             issue_base_i,
  input  logic [XLEN-1:0]             issue_offset_i,
  input  logic                        issue_is_load_i,
  input  logic [1:0]                  issue_size_i,
  input  logic [ROB_INDEX_WIDTH-1:0]  issue_rob_idx_i,
  output logic                        req_valid_o,
  input  logic                        req_ready_i,
  output logic [VIRTUAL_ADDR_LEN-1:0] req_vaddr_o,
  output logic                        req_is_load_o,
  output logic [1:0]                  req_size_o,
  output logic [ROB_INDEX_WIDTH-1:0]  req_rob_idx_o,
  output logic                        req_misalign_o
);

  localparam int VA = VIRTUAL_ADDR_LEN;

  typedef struct packed {
    logic [VA-1:0]              vaddr;
    logic                       isLoad;
    logic [1:0]                 size;
    logic [ROB_INDEX_WIDTH-1:0] robIdx;
    logic                       misalign;
  } req_t;

  typedef enum logic [1:0] {
    S_EMPTY,
    S_ONE,
    S_FULL
  } state_t;

  state_t        r_state;
  req_t          r_out;
  req_t          r_skid;
  logic          r_issueReady;

  logic [VA-1:0] w_vaddr;
  logic          w_misalign;
  req_t          w_newReq;
  logic          w_issueFire;
  logic          w_reqFire;
  logic          w_unusedUpper;

  // Upper operand bits never reach the address; carry out of bit VA-1 is dropped.
  assign w_vaddr       = issue_base_i[VA-1:0] + issue_offset_i[VA-1:0];
  assign w_unusedUpper = ^{issue_base_i[XLEN-1:VA], issue_offset_i[XLEN-1:VA]};

  always_comb begin
    w_misalign = 1'b0;
    case (issue_size_i)
      2'd0:    w_misalign = 1'b0;
      2'd1:    w_misalign = w_vaddr[0];
      2'd2:    w_misalign = |w_vaddr[1:0];
      default: w_misalign = |w_vaddr[2:0];
    endcase
  end

  assign w_newReq = '{vaddr:    w_vaddr,
                      isLoad:   issue_is_load_i,
                      size:     issue_size_i,
                      robIdx:   issue_rob_idx_i,
                      misalign: w_misalign};

  assign w_issueFire = issue_valid_i & r_issueReady;
  assign w_reqFire   = req_valid_o & req_ready_i;

  // Flush keeps the stale payload in the regs; only the valid state is cleared.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_EMPTY;
      r_issueReady <= 1'b1;
      r_out        <= '0;
      r_skid       <= '0;
    end else if (flush_i) begin
      r_state      <= S_EMPTY;
      r_issueReady <= 1'b1;
    end else begin
      case (r_state)
        S_EMPTY: begin
          if (w_issueFire) begin
            r_out   <= w_newReq;
            r_state <= S_ONE;
          end
        end
        S_ONE: begin
          if (w_issueFire && w_reqFire) begin
            r_out <= w_newReq;
          end else if (w_issueFire) begin
            r_skid       <= w_newReq;
            r_state      <= S_FULL;
            r_issueReady <= 1'b0;
          end else if (w_reqFire) begin
            r_state <= S_EMPTY;
          end
        end
        S_FULL: begin
          if (w_reqFire) begin
            r_out        <= r_skid;
            r_state      <= S_ONE;
            r_issueReady <= 1'b1;
          end
        end
        default: begin
          r_state      <= S_EMPTY;
          r_issueReady <= 1'b1;
        end
      endcase
    end
  end

  assign issue_ready_o  = r_issueReady;
  assign req_valid_o    = (r_state != S_EMPTY);
  assign req_vaddr_o    = r_out.vaddr;
  assign req_is_load_o  = r_out.isLoad;
  assign req_size_o     = r_out.size;
  assign req_rob_idx_o  = r_out.robIdx;
  assign req_misalign_o = r_out.misalign;

endmodule

// File: tb/tb_lsu_addr_stage.sv
// Self-checking bench for lsu_addr_stage: a queue model of held ops checked
// every cycle, plus directed literal checks and a randomized phase.
module tb_lsu_addr_stage;

  logic        clk;
  logic        rst;
  logic        flush_i;
  logic        issue_valid_i;
  logic        issue_ready_o;
  logic [63:0] issue_base_i;
  logic [63:0] issue_offset_i;
  logic        issue_is_load_i;
  logic [1:0]  issue_size_i;
  logic [5:0]  issue_rob_idx_i;
  logic        req_valid_o;
  logic        req_ready_i;
  logic [38:0] req_vaddr_o;
  logic        req_is_load_o;
  logic [1:0]  req_size_o;
  logic [5:0]  req_rob_idx_o;
  logic        req_misalign_o;

  lsu_addr_stage #(.XLEN(64), .VIRTUAL_ADDR_LEN(39), .ROB_INDEX_WIDTH(6)) dut (
    .clk             (clk),
    .rst             (rst),
    .flush_i         (flush_i),
    .issue_valid_i   (issue_valid_i),
    .issue_ready_o   (issue_ready_o),
    .issue_base_i    (issue_base_i),
    .issue_offset_i  (issue_offset_i),
    .issue_is_load_i (issue_is_load_i),
    .issue_size_i    (issue_size_i),
    .issue_rob_idx_i (issue_rob_idx_i),
    .req_valid_o     (req_valid_o),
    .req_ready_i     (req_ready_i),
    .req_vaddr_o     (req_vaddr_o),
    .req_is_load_o   (req_is_load_o),
    .req_size_o      (req_size_o),
    .req_rob_idx_o   (req_rob_idx_o),
    .req_misalign_o  (req_misalign_o)
  );

  typedef struct {
    logic [38:0] vaddr;
    bit          isLoad;
    bit [1:0]    size;
    bit [5:0]    rob;
    bit          mis;
  } op_t;

  op_t      modelQ[$];
  bit [5:0] deliveredLog[$];
  int       nChecks = 0;
  int       nFails  = 0;
  bit       checkOn = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected request from the arithmetic definition of the address and alignment.
  function automatic op_t makeOp(logic [63:0] b, logic [63:0] o, bit ld, bit [1:0] sz, bit [5:0] rob);
    op_t         r;
    logic [63:0] sum;
    sum      = (b % 64'h80_0000_0000 + o % 64'h80_0000_0000) % 64'h80_0000_0000;
    r.vaddr  = sum[38:0];
    r.isLoad = ld;
    r.size   = sz;
    r.rob    = rob;
    r.mis    = (sum % (64'd1 << sz)) != 64'd0;
    return r;
  endfunction

  task automatic checkOutput(string name, logic [63:0] actual, logic [63:0] expected);
    nChecks++;
    if (actual !== expected) begin
      nFails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Model: up to two ops held in issue order; accept only when fewer than two held.
  always @(posedge clk) begin
    bit iFire;
    bit rFire;
    iFire = issue_valid_i && (modelQ.size() < 2);
    rFire = (modelQ.size() > 0) && req_ready_i;
    if (req_valid_o === 1'b1 && req_ready_i) deliveredLog.push_back(req_rob_idx_o);
    if (rst || flush_i) begin
      modelQ.delete();
    end else begin
      if (rFire) void'(modelQ.pop_front());
      if (iFire) modelQ.push_back(makeOp(issue_base_i, issue_offset_i, issue_is_load_i,
                                         issue_size_i, issue_rob_idx_i));
    end
  end

  always @(negedge clk) begin
    if (checkOn) begin
      checkOutput("issue_ready", 64'(issue_ready_o), 64'(modelQ.size() < 2));
      checkOutput("req_valid", 64'(req_valid_o), 64'(modelQ.size() != 0));
      if (modelQ.size() != 0) begin
        checkOutput("req_vaddr", 64'(req_vaddr_o), 64'(modelQ[0].vaddr));
        checkOutput("req_is_load", 64'(req_is_load_o), 64'(modelQ[0].isLoad));
        checkOutput("req_size", 64'(req_size_o), 64'(modelQ[0].size));
        checkOutput("req_rob_idx", 64'(req_rob_idx_o), 64'(modelQ[0].rob));
        checkOutput("req_misalign", 64'(req_misalign_o), 64'(modelQ[0].mis));
      end
    end
  end

  task automatic applyStimulus(bit v, logic [63:0] b, logic [63:0] o, bit ld, bit [1:0] sz,
                               bit [5:0] rob, bit rr, bit fl, bit rs);
    issue_valid_i   = v;
    issue_base_i    = b;
    issue_offset_i  = o;
    issue_is_load_i = ld;
    issue_size_i    = sz;
    issue_rob_idx_i = rob;
    req_ready_i     = rr;
    flush_i         = fl;
    rst             = rs;
    @(negedge clk);
  endtask

  task automatic idle(bit rr, int n);
    repeat (n) applyStimulus(0, 64'd0, 64'd0, 0, 2'd0, 6'd0, rr, 0, 0);
  endtask

  task automatic checkResetOutputs(string tag);
    checkOutput({tag, "_valid"}, 64'(req_valid_o), 64'd0);
    checkOutput({tag, "_ready"}, 64'(issue_ready_o), 64'd1);
    checkOutput({tag, "_vaddr"}, 64'(req_vaddr_o), 64'd0);
    checkOutput({tag, "_is_load"}, 64'(req_is_load_o), 64'd0);
    checkOutput({tag, "_size"}, 64'(req_size_o), 64'd0);
    checkOutput({tag, "_rob"}, 64'(req_rob_idx_o), 64'd0);
    checkOutput({tag, "_misalign"}, 64'(req_misalign_o), 64'd0);
  endtask

  initial begin
    logic [63:0] b;
    logic [63:0] o;

    rst = 1'b1; flush_i = 1'b0; issue_valid_i = 1'b0; req_ready_i = 1'b0;
    issue_base_i = '0; issue_offset_i = '0; issue_is_load_i = 1'b0;
    issue_size_i = '0; issue_rob_idx_i = '0;
    repeat (2) @(negedge clk);
    checkOn = 1;
    checkResetOutputs("reset");

    $display("[TB] single op");
    applyStimulus(1, 64'h1000, 64'h10, 1, 2'd3, 6'd5, 0, 0, 0);
    checkOutput("t1_valid", 64'(req_valid_o), 64'd1);
    checkOutput("t1_vaddr", 64'(req_vaddr_o), 64'h1010);
    checkOutput("t1_misalign", 64'(req_misalign_o), 64'd0);
    checkOutput("t1_is_load", 64'(req_is_load_o), 64'd1);
    idle(1, 2);

    $display("[TB] wrap and misalign");
    applyStimulus(1, 64'h7F_FFFF_FFFF, 64'd1, 0, 2'd1, 6'd6, 0, 0, 0);
    checkOutput("t2_wrap_vaddr", 64'(req_vaddr_o), 64'd0);
    checkOutput("t2_wrap_misalign", 64'(req_misalign_o), 64'd0);
    idle(1, 2);
    applyStimulus(1, 64'h1001, 64'd0, 1, 2'd2, 6'd7, 0, 0, 0);
    checkOutput("t2_mis_vaddr", 64'(req_vaddr_o), 64'h1001);
    checkOutput("t2_mis_flag", 64'(req_misalign_o), 64'd1);
    idle(1, 2);

    $display("[TB] backpressure");
    deliveredLog.delete();
    applyStimulus(1, 64'h2000, 64'h8, 1, 2'd3, 6'd1, 0, 0, 0);
    applyStimulus(1, 64'h2000, 64'h10, 1, 2'd3, 6'd2, 0, 0, 0);
    checkOutput("t3_ready_after_op2", 64'(issue_ready_o), 64'd0);
    applyStimulus(1, 64'h2000, 64'h18, 0, 2'd3, 6'd3, 0, 0, 0);
    checkOutput("t3_ready_held", 64'(issue_ready_o), 64'd0);
    checkOutput("t3_head_rob", 64'(req_rob_idx_o), 64'd1);
    applyStimulus(1, 64'h2000, 64'h18, 0, 2'd3, 6'd3, 1, 0, 0);
    applyStimulus(1, 64'h2000, 64'h18, 0, 2'd3, 6'd3, 1, 0, 0);
    idle(1, 2);
    checkOutput("t3_delivered_count", 64'(deliveredLog.size()), 64'd3);
    for (int i = 0; i < 3 && i < deliveredLog.size(); i++)
      checkOutput("t3_order", 64'(deliveredLog[i]), 64'(i + 1));

    $display("[TB] streaming");
    deliveredLog.delete();
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1, {$urandom, $urandom}, 64'($urandom_range(0, 255)), 1'($urandom),
                    2'($urandom), 6'(i), 1, 0, 0);
      checkOutput("t4_ready", 64'(issue_ready_o), 64'd1);
      checkOutput("t4_valid", 64'(req_valid_o), 64'd1);
    end
    idle(1, 1);
    checkOutput("t4_delivered_count", 64'(deliveredLog.size()), 64'd20);
    for (int i = 0; i < 20 && i < deliveredLog.size(); i++)
      checkOutput("t4_order", 64'(deliveredLog[i]), 64'(i));
    idle(1, 1);

    $display("[TB] flush in full");
    applyStimulus(1, 64'h3000, 64'h0, 1, 2'd2, 6'd40, 0, 0, 0);
    applyStimulus(1, 64'h3000, 64'h4, 1, 2'd2, 6'd41, 0, 0, 0);
    deliveredLog.delete();
    applyStimulus(1, 64'h3000, 64'h8, 1, 2'd2, 6'd42, 0, 1, 0);
    checkOutput("t5_valid", 64'(req_valid_o), 64'd0);
    checkOutput("t5_ready", 64'(issue_ready_o), 64'd1);
    idle(1, 4);
    checkOutput("t5_none_delivered", 64'(deliveredLog.size()), 64'd0);

    $display("[TB] reset in one");
    applyStimulus(1, 64'h4000, 64'h3, 0, 2'd0, 6'd50, 0, 0, 0);
    checkOutput("t6_valid_before", 64'(req_valid_o), 64'd1);
    applyStimulus(1, 64'h4000, 64'h5, 0, 2'd0, 6'd51, 0, 0, 1);
    checkResetOutputs("t6");
    applyStimulus(1, 64'h5000, 64'h6, 1, 2'd1, 6'd52, 0, 0, 0);
    checkOutput("t6_resume_valid", 64'(req_valid_o), 64'd1);
    checkOutput("t6_resume_vaddr", 64'(req_vaddr_o), 64'h5006);
    checkOutput("t6_resume_rob", 64'(req_rob_idx_o), 64'd52);
    idle(1, 2);

    $display("[TB] random phase");
    for (int i = 0; i < 3000; i++) begin
      case ($urandom_range(0, 2))
        0:       b = {$urandom, $urandom};
        1:       b = 64'h7F_FFFF_FFF0 + 64'($urandom_range(0, 15));
        default: b = 64'($urandom_range(0, 65535));
      endcase
      o = ($urandom_range(0, 3) == 0) ? {$urandom, $urandom} : 64'($urandom_range(0, 31));
      applyStimulus($urandom_range(0, 99) < 70, b, o, 1'($urandom), 2'($urandom), 6'($urandom),
                    $urandom_range(0, 99) < 60, $urandom_range(0, 99) < 3,
                    $urandom_range(0, 199) < 2);
    end
    idle(1, 3);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
